serial_sub_4bit: RTL

- Bit-serial subtractor that computes `diff = a - b - bin`, one bit per clock, LSB first, using a single 1-bit full subtractor and a borrow flip-flop.
- It is the inverse-operation counterpart of the team's 4-bit ripple full adder.
- It sits in the same arithmetic test area as that adder, where its results can be cross-checked (`a == diff + b + bin`).
- It exposes a start/busy/done handshake so a bench or controller can issue operations back to back.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/full_sub_1bit.sv | 21 ++
 rtl/serial_sub_4bit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Contents:
//   SUB_WIDTH_DEFAULT - default operand/result width
//   state_e           - FSM state encoding (IDLE=0, SHIFT=1, DONE=2; 3 is illegal)
package serial_sub_pkg;

  localparam int unsigned SUB_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_sub_1bit.sv
// One-bit full subtractor cell, the subtracting twin of the adder's 1-bit
// full-adder cell. Purely combinational.
// Ports:
//   a    - minuend bit
//   b    - subtrahend bit
//   bin  - borrow in
//   d    - difference bit, a ^ b ^ bin
//   bout - borrow out, set when a < b + bin
module full_sub_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when the bits tie and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_4bit.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through a single full_sub_1bit cell and a borrow flop.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   start - request, only sampled in IDLE
//   a, b  - minuend / subtrahend, captured on the accepting edge
//   bin   - borrow in, captured on the accepting edge
//   diff  - result, held from done until the next accepted start
//   bout  - final borrow out, same hold rule as diff
//   busy  - high while in SHIFT or DONE
//   done  - one-cycle pulse when diff/bout become valid
module serial_sub_4bit
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             d_s;
  logic             br_next_s;

  full_sub_1bit u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (d_s),
    .bout (br_next_s)
  );

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = {CNT_W{1'b0}};
          res_d   = {WIDTH{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        res_d = {d_s, res_q[WIDTH-1:1]};
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = br_next_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // The last bit is still in flight, so publish the shifted value
          // directly; diff/bout and done then appear together on DONE entry.
          state_d = ST_DONE;
          diff_d  = {d_s, res_q[WIDTH-1:1]};
          bout_d  = br_next_s;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        // The unused encoding falls back to IDLE.
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SHIFT) || (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      diff_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
